// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, mret and enabled interrupts, drains the
// pipeline, commits mepc/mcause via the CSR file and redirects fetch.
module trap_ctrl #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DRAIN_TO = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exp_req_i,
  input  logic [3:0]      exp_cause_i,
  input  logic [XLEN-1:0] exp_pc_i,
  input  logic            mret_ena_i,
  input  logic            ext_irq_i,
  input  logic            sft_irq_i,
  input  logic            tmr_irq_i,
  input  logic            meie_i,
  input  logic            msie_i,
  input  logic            mtie_i,
  input  logic            glb_irq_i,
  input  logic [XLEN-1:0] pc_nxt_i,
  input  logic            pipe_idle_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            trap_wen_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mret_o,
  output logic            redirect_vld_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    SAVE  = 3'd2,
    JUMP  = 3'd3,
    MRET  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  cause_q;
  logic [XLEN-1:0]  pc_q;

  logic             take_trap_c;
  logic [XLEN-1:0]  take_cause_c;
  logic [XLEN-1:0]  take_pc_c;
  logic [XLEN-1:0]  vec_base_c;
  logic [XLEN-1:0]  jump_pc_c;

  function automatic logic [XLEN-1:0] mk_cause(input logic irq, input logic [3:0] code);
    return {irq, {(XLEN-5){1'b0}}, code};
  endfunction

  // Trap-entry arbitration; mret outranks interrupts but not exceptions
  always_comb begin
    take_trap_c  = 1'b0;
    take_cause_c = '0;
    take_pc_c    = '0;
    if (exp_req_i) begin
      take_trap_c  = 1'b1;
      take_cause_c = mk_cause(1'b0, exp_cause_i);
      take_pc_c    = exp_pc_i;
    end else if (!mret_ena_i) begin
      if (glb_irq_i && ext_irq_i && meie_i) begin
        take_trap_c  = 1'b1;
        take_cause_c = mk_cause(1'b1, 4'd11);
        take_pc_c    = pc_nxt_i;
      end else if (glb_irq_i && sft_irq_i && msie_i) begin
        take_trap_c  = 1'b1;
        take_cause_c = mk_cause(1'b1, 4'd3);
        take_pc_c    = pc_nxt_i;
      end else if (glb_irq_i && tmr_irq_i && mtie_i) begin
        take_trap_c  = 1'b1;
        take_cause_c = mk_cause(1'b1, 4'd7);
        take_pc_c    = pc_nxt_i;
      end
    end
  end

  // Handler target: aligned base, plus 4*code for interrupts in vectored mode
  assign vec_base_c = {mtvec_i[XLEN-1:2], 2'b00};
  assign jump_pc_c  = vec_base_c +
                      (((mtvec_i[1:0] == 2'b01) && cause_q[XLEN-1]) ?
                       XLEN'({cause_q[3:0], 2'b00}) : '0);

  // Sequencer state and registered, state-decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      cause_q        <= '0;
      pc_q           <= '0;
      stall_o        <= 1'b0;
      flush_o        <= 1'b0;
      trap_wen_o     <= 1'b0;
      mcause_o       <= '0;
      mepc_o         <= '0;
      mret_o         <= 1'b0;
      redirect_vld_o <= 1'b0;
      redirect_pc_o  <= '0;
      busy_o         <= 1'b0;
    end else begin
      flush_o        <= 1'b0;
      trap_wen_o     <= 1'b0;
      mret_o         <= 1'b0;
      redirect_vld_o <= 1'b0;
      case (state)
        IDLE: begin
          if (take_trap_c) begin
            cause_q <= take_cause_c;
            pc_q    <= take_pc_c;
            cnt     <= '0;
            state   <= DRAIN;
            stall_o <= 1'b1;
            busy_o  <= 1'b1;
          end else if (mret_ena_i) begin
            state          <= MRET;
            stall_o        <= 1'b1;
            busy_o         <= 1'b1;
            flush_o        <= 1'b1;
            mret_o         <= 1'b1;
            redirect_vld_o <= 1'b1;
            redirect_pc_o  <= mepc_i;
          end
        end
        DRAIN: begin
          if (pipe_idle_i || (cnt == CNT_LAST)) begin
            state      <= SAVE;
            flush_o    <= 1'b1;
            trap_wen_o <= 1'b1;
            mcause_o   <= cause_q;
            mepc_o     <= pc_q;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAVE: begin
          state          <= JUMP;
          redirect_vld_o <= 1'b1;
          redirect_pc_o  <= jump_pc_c;
        end
        JUMP, MRET: begin
          state   <= IDLE;
          stall_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          stall_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl with a directed prologue.
module tb_trap_ctrl;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned DRAIN_TO = 16;
  localparam int N    = 1700;
  localparam int TAIL = 40;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            exp_req_i = 1'b0;
  logic [3:0]      exp_cause_i = '0;
  logic [XLEN-1:0] exp_pc_i = '0;
  logic            mret_ena_i = 1'b0;
  logic            ext_irq_i = 1'b0, sft_irq_i = 1'b0, tmr_irq_i = 1'b0;
  logic            meie_i = 1'b0, msie_i = 1'b0, mtie_i = 1'b0, glb_irq_i = 1'b0;
  logic [XLEN-1:0] pc_nxt_i = '0;
  logic            pipe_idle_i = 1'b0;
  logic [XLEN-1:0] mtvec_i = '0;
  logic [XLEN-1:0] mepc_i = '0;
  logic            stall_o, flush_o, trap_wen_o, mret_o, redirect_vld_o, busy_o;
  logic [XLEN-1:0] mcause_o, mepc_o, redirect_pc_o;

  trap_ctrl #(.XLEN(XLEN), .DRAIN_TO(DRAIN_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_req_i(exp_req_i), .exp_cause_i(exp_cause_i), .exp_pc_i(exp_pc_i),
    .mret_ena_i(mret_ena_i),
    .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i), .tmr_irq_i(tmr_irq_i),
    .meie_i(meie_i), .msie_i(msie_i), .mtie_i(mtie_i), .glb_irq_i(glb_irq_i),
    .pc_nxt_i(pc_nxt_i), .pipe_idle_i(pipe_idle_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .stall_o(stall_o), .flush_o(flush_o), .trap_wen_o(trap_wen_o),
    .mcause_o(mcause_o), .mepc_o(mepc_o), .mret_o(mret_o),
    .redirect_vld_o(redirect_vld_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Per-cycle stimulus
  logic            s_rst[N], s_exp[N], s_mret[N], s_ext[N], s_sft[N], s_tmr[N];
  logic            s_meie[N], s_msie[N], s_mtie[N], s_glb[N], s_pidle[N];
  logic [3:0]      s_cause[N];
  logic [XLEN-1:0] s_exp_pc[N], s_pc_nxt[N], s_mtvec[N], s_mepc[N];

  // Expected per-cycle behaviour from the reference model
  logic            e_busy[N], e_flush[N], e_mret[N], e_wen[N], e_redir[N];
  logic [XLEN-1:0] e_cause[N], e_epc[N], e_rpc[N];

  typedef struct {
    int              cyc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } rec_t;

  rec_t wen_q[$];
  rec_t redir_q[$];

  int              obs_wen_cyc[$];
  logic [XLEN-1:0] obs_wen_cause[$];
  logic [XLEN-1:0] obs_wen_epc[$];
  int              obs_rd_cyc[$];
  logic [XLEN-1:0] obs_rd_pc[$];

  int checks = 0;
  int errors = 0;
  int cur = 0;
  bit running = 1'b0;

  task automatic chk(input string name, input int cyc, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_inputs(input int c);
    s_rst[c] = 1'b1;   s_exp[c] = 1'b0;  s_mret[c] = 1'b0;
    s_ext[c] = 1'b0;   s_sft[c] = 1'b0;  s_tmr[c] = 1'b0;
    s_meie[c] = 1'b0;  s_msie[c] = 1'b0; s_mtie[c] = 1'b0; s_glb[c] = 1'b0;
    s_pidle[c] = 1'b1; s_cause[c] = '0;  s_exp_pc[c] = '0; s_pc_nxt[c] = '0;
    s_mtvec[c] = '0;   s_mepc[c] = '0;
  endtask

  task automatic build_stimulus();
    logic [XLEN-1:0] v;
    for (int c = 0; c < N; c++) clear_inputs(c);
    s_rst[0] = 1'b0; s_rst[1] = 1'b0;
    // T1: external irq, direct mtvec
    s_ext[3] = 1'b1; s_meie[3] = 1'b1; s_glb[3] = 1'b1; s_pc_nxt[3] = 64'h8000_0100;
    for (int c = 3; c < 8; c++) s_mtvec[c] = 64'h8000_0000;
    // T2: same, vectored mtvec
    s_ext[8] = 1'b1; s_meie[8] = 1'b1; s_glb[8] = 1'b1; s_pc_nxt[8] = 64'h8000_0100;
    for (int c = 8; c < 13; c++) s_mtvec[c] = 64'h8000_0001;
    // T3: exception and timer irq together, timer held with glb low afterwards
    s_exp[13] = 1'b1; s_cause[13] = 4'd2; s_exp_pc[13] = 64'h0000_1234; s_glb[13] = 1'b1;
    for (int c = 13; c < 23; c++) begin s_tmr[c] = 1'b1; s_mtie[c] = 1'b1; end
    // T4: software irq, pipeline never idles
    s_sft[24] = 1'b1; s_msie[24] = 1'b1; s_glb[24] = 1'b1; s_pc_nxt[24] = 64'h8000_0300;
    for (int c = 25; c < 46; c++) s_pidle[c] = 1'b0;
    // T5: mret
    s_mret[46] = 1'b1; s_mepc[46] = 64'h8000_0204;
    // T6: reset in the middle of a drain
    s_exp[50] = 1'b1; s_cause[50] = 4'd5; s_exp_pc[50] = 64'h0000_5550;
    for (int c = 51; c < 63; c++) s_pidle[c] = 1'b0;
    s_rst[54] = 1'b0;
    // Random traffic
    for (int c = 64; c < N - TAIL; c++) begin
      s_rst[c]    = !((c % 397) == 200 || (c % 397) == 201);
      s_exp[c]    = ($urandom_range(0, 11) == 0);
      s_cause[c]  = 4'($urandom);
      s_exp_pc[c] = r64();
      s_mret[c]   = ($urandom_range(0, 19) == 0);
      s_ext[c]    = ($urandom_range(0, 3) == 0);
      s_sft[c]    = ($urandom_range(0, 3) == 0);
      s_tmr[c]    = ($urandom_range(0, 3) == 0);
      s_meie[c]   = 1'($urandom_range(0, 1));
      s_msie[c]   = 1'($urandom_range(0, 1));
      s_mtie[c]   = 1'($urandom_range(0, 1));
      s_glb[c]    = ($urandom_range(0, 2) == 0);
      s_pc_nxt[c] = r64();
      s_pidle[c]  = ((c % 150) < 20) ? 1'b0 : ($urandom_range(0, 2) == 0);
      s_mepc[c]   = r64();
      if ($urandom_range(0, 7) == 0) begin
        v = 64'hFFFF_FFFF_FFFF_FFF1;
      end else begin
        v = r64();
        v[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom);
      end
      s_mtvec[c] = v;
    end
  endtask

  // Reference model: event scheduling over the stimulus timeline
  task automatic build_model();
    int free_at = 0;
    bit trap, irq;
    logic [3:0] code;
    logic [XLEN-1:0] epc, base;
    int d, s, j;
    for (int c = 0; c < N; c++) begin
      e_busy[c] = 0; e_flush[c] = 0; e_mret[c] = 0; e_wen[c] = 0; e_redir[c] = 0;
      e_cause[c] = '0; e_epc[c] = '0; e_rpc[c] = '0;
    end
    for (int c = 0; c < N; c++) begin
      if (!s_rst[c]) begin
        for (int k = c; k < N; k++) begin
          e_busy[k] = 0; e_flush[k] = 0; e_mret[k] = 0; e_wen[k] = 0; e_redir[k] = 0;
        end
        free_at = c + 1;
        continue;
      end
      if (c < free_at) continue;
      trap = 0; irq = 0; code = '0; epc = '0;
      if (s_exp[c]) begin
        trap = 1; code = s_cause[c]; epc = s_exp_pc[c];
      end else if (s_mret[c]) begin
        e_busy[c+1] = 1; e_flush[c+1] = 1; e_mret[c+1] = 1;
        e_redir[c+1] = 1; e_rpc[c+1] = s_mepc[c];
        free_at = c + 2;
      end else if (s_glb[c] && s_ext[c] && s_meie[c]) begin
        trap = 1; irq = 1; code = 4'd11; epc = s_pc_nxt[c];
      end else if (s_glb[c] && s_sft[c] && s_msie[c]) begin
        trap = 1; irq = 1; code = 4'd3; epc = s_pc_nxt[c];
      end else if (s_glb[c] && s_tmr[c] && s_mtie[c]) begin
        trap = 1; irq = 1; code = 4'd7; epc = s_pc_nxt[c];
      end
      if (trap) begin
        d = DRAIN_TO;
        for (int k = 0; k < DRAIN_TO; k++) begin
          if (s_pidle[c+1+k]) begin d = k + 1; break; end
        end
        s = c + d + 1;
        j = s + 1;
        for (int k = c + 1; k <= j; k++) e_busy[k] = 1;
        e_wen[s] = 1; e_flush[s] = 1;
        e_cause[s] = {irq, 59'b0, code};
        e_epc[s] = epc;
        base = s_mtvec[s] & ~64'h3;
        if (s_mtvec[s][1:0] == 2'b01 && irq) base = base + 64'(4 * code);
        e_redir[j] = 1; e_rpc[j] = base;
        free_at = j + 1;
      end
    end
  endtask

  // Monitor: compare outputs each cycle and pop scoreboard entries on strobes
  always @(negedge clk) begin
    rec_t r;
    int c;
    if (running) begin
      c = cur;
      if (!s_rst[c]) begin
        chk("rst_strobes", c, 64'({stall_o, flush_o, trap_wen_o, mret_o, redirect_vld_o, busy_o}), '0);
        chk("rst_mcause", c, mcause_o, '0);
        chk("rst_mepc", c, mepc_o, '0);
        chk("rst_redirect_pc", c, redirect_pc_o, '0);
      end else begin
        chk("stall", c, 64'(stall_o), 64'(e_busy[c]));
        chk("busy", c, 64'(busy_o), 64'(e_busy[c]));
        chk("flush", c, 64'(flush_o), 64'(e_flush[c]));
        chk("mret", c, 64'(mret_o), 64'(e_mret[c]));
        if (trap_wen_o) begin
          obs_wen_cyc.push_back(c); obs_wen_cause.push_back(mcause_o); obs_wen_epc.push_back(mepc_o);
          if (wen_q.size() == 0) begin
            chk("trap_wen_unexpected", c, 64'd1, 64'd0);
          end else begin
            r = wen_q.pop_front();
            chk("trap_wen_cycle", c, 64'(c), 64'(r.cyc));
            chk("mcause", c, mcause_o, r.a);
            chk("mepc", c, mepc_o, r.b);
          end
        end
        if (redirect_vld_o) begin
          obs_rd_cyc.push_back(c); obs_rd_pc.push_back(redirect_pc_o);
          if (redir_q.size() == 0) begin
            chk("redirect_unexpected", c, 64'd1, 64'd0);
          end else begin
            r = redir_q.pop_front();
            chk("redirect_cycle", c, 64'(c), 64'(r.cyc));
            chk("redirect_pc", c, redirect_pc_o, r.a);
          end
        end
      end
    end
  end

  // Stimulus driver: apply cycle c and post its expected transactions
  initial begin
    rec_t r;
    build_stimulus();
    build_model();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rst_n       = s_rst[c];
      exp_req_i   = s_exp[c];   exp_cause_i = s_cause[c]; exp_pc_i = s_exp_pc[c];
      mret_ena_i  = s_mret[c];
      ext_irq_i   = s_ext[c];   sft_irq_i = s_sft[c];     tmr_irq_i = s_tmr[c];
      meie_i      = s_meie[c];  msie_i = s_msie[c];       mtie_i = s_mtie[c];
      glb_irq_i   = s_glb[c];   pc_nxt_i = s_pc_nxt[c];   pipe_idle_i = s_pidle[c];
      mtvec_i     = s_mtvec[c]; mepc_i = s_mepc[c];
      if (e_wen[c]) begin
        r.cyc = c; r.a = e_cause[c]; r.b = e_epc[c];
        wen_q.push_back(r);
      end
      if (e_redir[c]) begin
        r.cyc = c; r.a = e_rpc[c]; r.b = '0;
        redir_q.push_back(r);
      end
      cur = c;
      running = 1'b1;
    end
    @(posedge clk);
    running = 1'b0;
    chk("wen_leftover", N, 64'(wen_q.size()), 64'd0);
    chk("redirect_leftover", N, 64'(redir_q.size()), 64'd0);
    // Directed scenario checks against fixed values
    chk("directed_wen_count", 0, 64'(obs_wen_cyc.size() >= 4), 64'd1);
    chk("directed_rd_count", 0, 64'(obs_rd_cyc.size() >= 5), 64'd1);
    if (obs_wen_cyc.size() >= 4 && obs_rd_cyc.size() >= 5) begin
      chk("t1_wen_cycle", obs_wen_cyc[0], 64'(obs_wen_cyc[0]), 64'd5);
      chk("t1_mcause", obs_wen_cyc[0], obs_wen_cause[0], 64'h8000_0000_0000_000B);
      chk("t1_mepc", obs_wen_cyc[0], obs_wen_epc[0], 64'h8000_0100);
      chk("t1_redirect_cycle", obs_rd_cyc[0], 64'(obs_rd_cyc[0]), 64'd6);
      chk("t1_redirect_pc", obs_rd_cyc[0], obs_rd_pc[0], 64'h8000_0000);
      chk("t2_redirect_pc", obs_rd_cyc[1], obs_rd_pc[1], 64'h8000_002C);
      chk("t3_mcause", obs_wen_cyc[2], obs_wen_cause[2], 64'h2);
      chk("t4_wen_cycle", obs_wen_cyc[3], 64'(obs_wen_cyc[3]), 64'd41);
      chk("t4_mcause", obs_wen_cyc[3], obs_wen_cause[3], 64'h8000_0000_0000_0003);
      chk("t5_redirect_cycle", obs_rd_cyc[4], 64'(obs_rd_cyc[4]), 64'd47);
      chk("t5_redirect_pc", obs_rd_cyc[4], obs_rd_pc[4], 64'h8000_0204);
    end
    if (obs_wen_cyc.size() >= 5)
      chk("t6_no_trap_after_reset", obs_wen_cyc[4], 64'(obs_wen_cyc[4] >= 64), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
